// File: rtl/uart_regfile_v2.sv
// rtl/uart_regfile_v2.sv - word-mapped UART register file with W1C interrupt status and push/pop strobes
module uart_regfile_v2 #(
    parameter int          ADDR_W     = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          DIV_W      = 16,
    parameter int unsigned DIV_RESET  = 434,
    parameter logic [7:0]  CTRL_RESET = 8'h00
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_en,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rdata,
    output logic              rd_rdy,
    output logic [7:0]        ctrl,
    output logic [DIV_W-1:0]  baud_div,
    output logic [7:0]        tx_data,
    output logic              tx_push,
    input  logic              tx_busy,
    input  logic              tx_done_evt,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    input  logic              rx_evt,
    input  logic              ovr_evt,
    output logic              irq,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] BASE_EXT = (ADDR_W+1)'(BASE_ADDR);

    // Subtract in ADDR_W+1 bits so the borrow flags addresses below the base.
    function automatic logic [3:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] off;
        logic [3:0]      res;
        off      = {1'b0, addr} - BASE_EXT;
        res[3]   = !off[ADDR_W] && (off[ADDR_W-1:5] == '0) && (off[1:0] == 2'b00);
        res[2:0] = off[4:2];
        return res;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  lanes);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = lanes[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction

    logic [3:0]       w_dec, r_dec;
    logic [7:0]       wr_sel;
    logic [31:0]      rd_val;
    logic [2:0]       int_stat_q, int_stat_nxt, int_en_q, int_en_nxt, int_clr;
    logic [31:0]      scratch_q;

    always_comb begin
        w_dec  = decode(wr_addr);
        r_dec  = decode(rd_addr);
        wr_sel = (wr_en && w_dec[3]) ? (8'd1 << w_dec[2:0]) : 8'd0;

        int_clr      = (wr_sel[5] && be[0]) ? wdata[2:0] : 3'b000;
        int_en_nxt   = (wr_sel[6] && be[0]) ? wdata[2:0] : int_en_q;
        int_stat_nxt = (int_stat_q & ~int_clr) | {ovr_evt, tx_done_evt, rx_evt};

        case (r_dec[2:0])
            3'd0:    rd_val = {24'd0, ctrl};
            3'd1:    rd_val = 32'(baud_div);
            3'd3:    rd_val = {24'd0, rx_data};
            3'd4:    rd_val = {29'd0, irq, rx_valid, tx_busy};
            3'd5:    rd_val = {29'd0, int_stat_q};
            3'd6:    rd_val = {29'd0, int_en_q};
            3'd7:    rd_val = scratch_q;
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rdata      <= 32'd0;
            rd_rdy     <= 1'b0;
            ctrl       <= CTRL_RESET;
            baud_div   <= DIV_W'(DIV_RESET);
            tx_data    <= 8'd0;
            tx_push    <= 1'b0;
            rx_pop     <= 1'b0;
            irq        <= 1'b0;
            addr_err   <= 1'b0;
            int_stat_q <= 3'd0;
            int_en_q   <= 3'd0;
            scratch_q  <= 32'd0;
        end else begin
            // Read data comes from pre-write state, giving read-before-write on collisions.
            rd_rdy   <= rd_en;
            rdata    <= (rd_en && r_dec[3]) ? rd_val : 32'd0;
            rx_pop   <= rd_en && r_dec[3] && (r_dec[2:0] == 3'd3) && rx_valid;
            addr_err <= (wr_en && !w_dec[3]) || (rd_en && !r_dec[3]);
            tx_push  <= wr_sel[2] && be[0];

            if (wr_sel[0] && be[0])
                ctrl <= wdata[7:0];
            if (wr_sel[1])
                baud_div <= DIV_W'(merge(32'(baud_div), wdata, be));
            if (wr_sel[2] && be[0])
                tx_data <= wdata[7:0];
            if (wr_sel[7])
                scratch_q <= merge(scratch_q, wdata, be);

            int_en_q   <= int_en_nxt;
            int_stat_q <= int_stat_nxt;
            irq        <= |(int_stat_nxt & int_en_nxt);
        end
    end

endmodule

// File: tb/tb_uart_regfile_v2.sv
// tb/tb_uart_regfile_v2.sv - randomized and directed bench for uart_regfile_v2 against a register-map model
module tb_uart_regfile_v2;

    localparam int BASE = 32'h40;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [15:0] wr_addr = 16'd0, rd_addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        rd_rdy;
    logic [7:0]  ctrl;
    logic [15:0] baud_div;
    logic [7:0]  tx_data;
    logic        tx_push;
    logic        tx_busy = 1'b0, tx_done_evt = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0, rx_pop;
    logic        rx_evt = 1'b0, ovr_evt = 1'b0;
    logic        irq, addr_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_reg [8];
    logic [2:0]  m_int;
    logic        m_irq, m_rdy, m_pop, m_err, m_push;
    logic [31:0] m_rdata;
    logic [7:0]  m_tx;

    uart_regfile_v2 #(.ADDR_W(16), .BASE_ADDR(BASE), .DIV_W(16), .DIV_RESET(434), .CTRL_RESET(8'h00)) dut (
        .clk(clk), .rstb(rstb), .wr_en(wr_en), .be(be), .wr_addr(wr_addr), .wdata(wdata),
        .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata), .rd_rdy(rd_rdy), .ctrl(ctrl),
        .baud_div(baud_div), .tx_data(tx_data), .tx_push(tx_push), .tx_busy(tx_busy),
        .tx_done_evt(tx_done_evt), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .rx_evt(rx_evt), .ovr_evt(ovr_evt), .irq(irq), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_decode(input logic [15:0] a, output int idx);
        int off;
        off = int'(a) - BASE;
        idx = (off >>> 2) & 7;
        return (off >= 0) && (off < 32) && (off % 4 == 0);
    endfunction

    function automatic logic [31:0] m_mask(input int idx);
        case (idx)
            0:       return 32'h0000_00FF;
            1:       return 32'h0000_FFFF;
            6:       return 32'h0000_0007;
            7:       return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        m_reg[1] = 32'd434;
        m_int = 3'd0; m_irq = 1'b0; m_rdy = 1'b0; m_pop = 1'b0;
        m_err = 1'b0; m_push = 1'b0; m_rdata = 32'd0; m_tx = 8'd0;
    endtask

    task automatic model_step();
        int  wi, ri;
        bit  wm, rm;
        logic [2:0] clr;
        if (!rstb) begin
            model_reset();
            return;
        end
        wm = m_decode(wr_addr, wi);
        rm = m_decode(rd_addr, ri);
        m_rdy = rd_en;
        m_rdata = 32'd0;
        if (rd_en && rm) begin
            case (ri)
                3:       m_rdata = {24'd0, rx_data};
                4:       m_rdata = {29'd0, m_irq, rx_valid, tx_busy};
                5:       m_rdata = {29'd0, m_int};
                2:       m_rdata = 32'd0;
                default: m_rdata = m_reg[ri];
            endcase
        end
        m_pop  = rd_en && rm && ri == 3 && rx_valid;
        m_err  = (wr_en && !wm) || (rd_en && !rm);
        m_push = 1'b0;
        clr    = 3'd0;
        if (wr_en && wm) begin
            if (ri >= 0 && wi == 2 && be[0]) begin
                m_tx = wdata[7:0];
                m_push = 1'b1;
            end else if (wi == 5 && be[0]) begin
                clr = wdata[2:0];
            end else if (wi == 0 || wi == 1 || wi == 6 || wi == 7) begin
                for (int l = 0; l < 4; l++)
                    if (be[l]) m_reg[wi][8*l +: 8] = wdata[8*l +: 8];
                m_reg[wi] = m_reg[wi] & m_mask(wi);
            end
        end
        m_int = (m_int & ~clr) | {ovr_evt, tx_done_evt, rx_evt};
        m_irq = |(m_int & m_reg[6][2:0]);
    endtask

    task automatic compare();
        check("rdata", rdata, m_rdata);
        check("rd_rdy", 32'(rd_rdy), 32'(m_rdy));
        check("ctrl", 32'(ctrl), m_reg[0]);
        check("baud_div", 32'(baud_div), m_reg[1]);
        check("tx_data", 32'(tx_data), 32'(m_tx));
        check("tx_push", 32'(tx_push), 32'(m_push));
        check("rx_pop", 32'(rx_pop), 32'(m_pop));
        check("irq", 32'(irq), 32'(m_irq));
        check("addr_err", 32'(addr_err), 32'(m_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        compare();
        wr_en = 1'b0; rd_en = 1'b0;
        rx_evt = 1'b0; tx_done_evt = 1'b0; ovr_evt = 1'b0;
    endtask

    task automatic do_wr(input int addr, input logic [31:0] d, input logic [3:0] b);
        wr_en = 1'b1; wr_addr = 16'(addr); wdata = d; be = b;
        cyc();
    endtask

    task automatic do_rd(input int addr);
        rd_en = 1'b1; rd_addr = 16'(addr);
        cyc();
    endtask

    initial begin
        logic [31:0] rst_exp [8];
        rst_exp = '{32'd0, 32'd434, 32'd0, 32'h5A, 32'h3, 32'd0, 32'd0, 32'd0};
        model_reset();
        cyc();
        cyc();
        rstb = 1'b1;
        cyc();

        rx_data = 8'h5A; rx_valid = 1'b1; tx_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            do_rd(BASE + 4 * k);
            check($sformatf("rst_read_%0d", k), rdata, rst_exp[k]);
            check("rst_rd_rdy", 32'(rd_rdy), 32'd1);
        end
        cyc();
        check("rd_rdy_drop", 32'(rd_rdy), 32'd0);
        rx_valid = 1'b0; tx_busy = 1'b0;

        do_wr(BASE + 8'h1C, 32'hA5A5A5A5, 4'b1111);
        do_wr(BASE + 8'h1C, 32'h12345678, 4'b0101);
        do_rd(BASE + 8'h1C);
        check("scratch_merge", rdata, 32'hA534A578);
        do_wr(BASE + 8'h04, 32'hFFFFFFFF, 4'b1111);
        do_rd(BASE + 8'h04);
        check("baud_trunc", rdata, 32'h0000FFFF);

        do_wr(BASE + 8'h08, 32'h55, 4'b0001);
        check("tx_data_55", 32'(tx_data), 32'h55);
        check("tx_push_hi", 32'(tx_push), 32'd1);
        cyc();
        check("tx_push_lo", 32'(tx_push), 32'd0);
        do_wr(BASE + 8'h08, 32'hAA, 4'b1110);
        check("tx_no_push", 32'(tx_push), 32'd0);
        check("tx_data_keep", 32'(tx_data), 32'h55);

        rx_valid = 1'b1; rx_data = 8'h3C;
        do_rd(BASE + 8'h0C);
        check("rx_rdata", rdata, 32'h3C);
        check("rx_pop_hi", 32'(rx_pop), 32'd1);
        rx_valid = 1'b0;
        do_rd(BASE + 8'h0C);
        check("rx_pop_lo", 32'(rx_pop), 32'd0);

        do_wr(BASE + 8'h18, 32'h1, 4'b0001);
        rx_evt = 1'b1;
        cyc();
        check("irq_set", 32'(irq), 32'd1);
        rx_evt = 1'b1;
        do_wr(BASE + 8'h14, 32'h1, 4'b0001);
        do_rd(BASE + 8'h14);
        check("set_wins", rdata, 32'h1);
        do_wr(BASE + 8'h14, 32'h1, 4'b0001);
        check("irq_clear", 32'(irq), 32'd0);
        ovr_evt = 1'b1;
        cyc();
        check("ovr_masked_irq", 32'(irq), 32'd0);
        do_rd(BASE + 8'h14);
        check("ovr_stat", rdata, 32'h4);

        for (int k = 0; k < 3; k++) begin
            int a;
            a = (k == 0) ? BASE + 32'h20 : (k == 1) ? BASE - 4 : BASE + 2;
            do_wr(a, 32'hFFFFFFFF, 4'b1111);
            check("unmap_wr_err", 32'(addr_err), 32'd1);
            check("unmap_ctrl", 32'(ctrl), 32'h0);
            do_rd(a);
            check("unmap_rd", rdata, 32'd0);
            check("unmap_rdy", 32'(rd_rdy), 32'd1);
            cyc();
            check("unmap_err_drop", 32'(addr_err), 32'd0);
        end

        rx_evt = 1'b1;
        cyc();
        do_rd(BASE + 8'h1C);
        rd_en = 1'b1; rd_addr = 16'(BASE);
        rstb = 1'b0;
        #1;
        check("rst_async_rdy", 32'(rd_rdy), 32'd0);
        check("rst_async_rdata", rdata, 32'd0);
        check("rst_async_irq", 32'(irq), 32'd0);
        model_reset();
        rx_evt = 1'b1;
        cyc();
        cyc();
        rstb = 1'b1;
        cyc();

        for (int n = 0; n < 1500; n++) begin
            int r;
            rx_data  = 8'($urandom);
            rx_valid = 1'($urandom_range(0, 1));
            tx_busy  = 1'($urandom_range(0, 1));
            rx_evt      = ($urandom_range(0, 7) == 0);
            tx_done_evt = ($urandom_range(0, 7) == 0);
            ovr_evt     = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 9);
            wr_addr = 16'((r < 8) ? BASE + 4 * r : BASE - 8 + $urandom_range(0, 48));
            r = $urandom_range(0, 9);
            rd_addr = 16'((r < 8) ? BASE + 4 * r : BASE - 8 + $urandom_range(0, 48));
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            be    = 4'($urandom);
            wdata = $urandom;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
